servo_pwm_stepper: RTL and testbench

Consumes the 1-cycle, 5 Hz tick pulse produced by the system clock divider and the decoded steering command. On each tick it steps a servo position register up, down or to centre, saturating at the mechanical limits. It then drives a standard 50 Hz hobby-servo PWM output from that position. The pulse width is double-buffered so it changes only at frame boundaries, which keeps pulses glitch-free.

---
 rtl/servo_pwm_stepper.sv | 81 ++++++++
 tb/tb_servo_pwm_stepper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_stepper.sv
// Servo position stepper with a double-buffered 50 Hz hobby-servo PWM generator.
// Position moves one step per accepted tick; pulse width follows at frame boundaries.
module servo_pwm_stepper #(
    parameter int PERIOD_CYC = 2000000,
    parameter int MIN_CYC    = 100000,
    parameter int MAX_CYC    = 200000,
    parameter int CENTER_CYC = 150000,
    parameter int STEP_CYC   = 5000,
    parameter int W          = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         en_i,
    input  logic [1:0]   cmd_i,
    output logic         pwm_o,
    output logic [W-1:0] pos_o,
    output logic         frame_o,
    output logic         at_min_o,
    output logic         at_max_o
);

    localparam logic [W-1:0] PERIOD_LAST = W'(PERIOD_CYC - 1);
    localparam logic [W-1:0] MIN_POS     = W'(MIN_CYC);
    localparam logic [W-1:0] MAX_POS     = W'(MAX_CYC);
    localparam logic [W-1:0] CENTER_POS  = W'(CENTER_CYC);
    localparam logic [W-1:0] STEP        = W'(STEP_CYC);

    logic [W-1:0] pos;
    logic [W-1:0] shadow;
    logic [W-1:0] cnt;
    logic         started;
    logic         accept;
    logic         frame_start;
    logic [W-1:0] next_pos;
    logic [W-1:0] next_cnt;
    logic [W-1:0] next_width;

    assign accept = tick_i & en_i;

    // 'started' is clear out of reset so the first edge with rst low opens frame 0.
    assign frame_start = !started || (cnt == PERIOD_LAST);
    assign next_cnt    = frame_start ? '0 : cnt + W'(1);
    assign next_width  = frame_start ? pos : shadow;

    // Headroom is measured as a distance from the limit, so nothing can wrap.
    always_comb begin
        next_pos = pos;
        if (accept) begin
            unique case (cmd_i)
                2'b01:   next_pos = ((MAX_POS - pos) < STEP) ? MAX_POS : pos + STEP;
                2'b10:   next_pos = ((pos - MIN_POS) < STEP) ? MIN_POS : pos - STEP;
                2'b11:   next_pos = CENTER_POS;
                default: next_pos = pos;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos     <= CENTER_POS;
            shadow  <= CENTER_POS;
            cnt     <= '0;
            started <= 1'b0;
            pwm_o   <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            pos     <= next_pos;
            shadow  <= next_width;
            cnt     <= next_cnt;
            started <= 1'b1;
            pwm_o   <= (next_cnt < next_width);
            frame_o <= frame_start;
        end
    end

    assign pos_o    = pos;
    assign at_min_o = (pos == MIN_POS);
    assign at_max_o = (pos == MAX_POS);

endmodule

// File: tb/tb_servo_pwm_stepper.sv
// Directed bench for servo_pwm_stepper using scaled-down timing parameters.
// Expected positions and widths are hand-computed for PERIOD=400, MIN=10, MAX=50, CENTER=31, STEP=2.
module tb_servo_pwm_stepper;

    localparam int PERIOD = 400;
    localparam int MINC   = 10;
    localparam int MAXC   = 50;
    localparam int CENTER = 31;
    localparam int STEP   = 2;
    localparam int W      = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick_i = 1'b0;
    logic         en_i = 1'b0;
    logic [1:0]   cmd_i = 2'b00;
    logic         pwm_o;
    logic [W-1:0] pos_o;
    logic         frame_o;
    logic         at_min_o;
    logic         at_max_o;

    int checks = 0;
    int errors = 0;

    servo_pwm_stepper #(
        .PERIOD_CYC(PERIOD),
        .MIN_CYC(MINC),
        .MAX_CYC(MAXC),
        .CENTER_CYC(CENTER),
        .STEP_CYC(STEP),
        .W(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_i(tick_i),
        .en_i(en_i),
        .cmd_i(cmd_i),
        .pwm_o(pwm_o),
        .pos_o(pos_o),
        .frame_o(frame_o),
        .at_min_o(at_min_o),
        .at_max_o(at_max_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] cmd);
        tick_i = 1'b1;
        en_i   = en;
        cmd_i  = cmd;
        stepCycle();
        tick_i = 1'b0;
        cmd_i  = 2'b00;
    endtask

    task automatic countCycles(input int n, output int high);
        high = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_o) high++;
            stepCycle();
        end
    endtask

    // Counts from the current cycle up to (not including) the next frame_o cycle.
    task automatic measureFrame(output int high, output int total);
        int bad_rise = 0;
        logic prev = 1'b1;
        high  = 0;
        total = 0;
        do begin
            if (pwm_o && !prev && !frame_o) bad_rise++;
            prev = pwm_o;
            if (pwm_o) high++;
            total++;
            stepCycle();
        end while (!frame_o && total < 2 * PERIOD);
        checkOutput("rise_without_frame", bad_rise, 0);
        checkOutput("frame_pwm_coincide", int'(pwm_o), 1);
    endtask

    task automatic waitFrameStart();
        int n = 0;
        while (!frame_o && n < 2 * PERIOD) begin
            stepCycle();
            n++;
        end
        checkOutput("wait_frame", int'(frame_o), 1);
    endtask

    int up_exp[11]   = '{33, 35, 37, 39, 41, 43, 45, 47, 49, 50, 50};
    int down_exp[12] = '{29, 27, 25, 23, 21, 19, 17, 15, 13, 11, 10, 10};

    initial begin
        int high;
        int total;
        int high_b;

        // Reset state
        repeat (3) stepCycle();
        checkOutput("rst_pos", int'(pos_o), CENTER);
        checkOutput("rst_pwm", int'(pwm_o), 0);
        checkOutput("rst_frame", int'(frame_o), 0);
        checkOutput("rst_at_min", int'(at_min_o), 0);
        checkOutput("rst_at_max", int'(at_max_o), 0);

        // First frame opens on the first edge with rst low
        rst = 1'b0;
        stepCycle();
        checkOutput("first_frame_o", int'(frame_o), 1);
        checkOutput("first_pwm", int'(pwm_o), 1);
        measureFrame(high, total);
        checkOutput("f1_high", high, CENTER);
        checkOutput("f1_period", total, PERIOD);

        // Step up with saturation at MAX
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 2'b01);
            checkOutput($sformatf("up_%0d", i), int'(pos_o), up_exp[i]);
        end
        checkOutput("up_at_max", int'(at_max_o), 1);
        checkOutput("up_at_min", int'(at_min_o), 0);
        waitFrameStart();
        measureFrame(high, total);
        checkOutput("max_high", high, MAXC);
        checkOutput("max_period", total, PERIOD);

        // Centre, then ticks while disabled
        applyStimulus(1'b1, 2'b11);
        checkOutput("centre_pos", int'(pos_o), CENTER);
        checkOutput("centre_at_max", int'(at_max_o), 0);
        checkOutput("centre_at_min", int'(at_min_o), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b01);
        checkOutput("disabled_pos", int'(pos_o), CENTER);
        cmd_i = 2'b10;
        repeat (3) stepCycle();
        checkOutput("cmd_no_tick_pos", int'(pos_o), CENTER);

        // Step down with saturation at MIN
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 2'b10);
            checkOutput($sformatf("down_%0d", i), int'(pos_o), down_exp[i]);
        end
        checkOutput("down_at_min", int'(at_min_o), 1);
        waitFrameStart();
        measureFrame(high, total);
        checkOutput("min_high", high, MINC);

        // Tick on the frame-start edge: current frame keeps the old width
        applyStimulus(1'b1, 2'b11);
        checkOutput("recentre_pos", int'(pos_o), CENTER);
        countCycles(PERIOD - 2, high);
        applyStimulus(1'b1, 2'b01);
        checkOutput("edge_tick_frame_o", int'(frame_o), 1);
        checkOutput("edge_tick_pos", int'(pos_o), 33);
        measureFrame(high, total);
        checkOutput("edge_cur_high", high, CENTER);
        measureFrame(high, total);
        checkOutput("edge_next_high", high, 33);

        // Mid-frame tick only affects the following frame
        countCycles(10, high);
        if (pwm_o) high++;
        applyStimulus(1'b1, 2'b01);
        checkOutput("mid_tick_pos", int'(pos_o), 35);
        measureFrame(high_b, total);
        checkOutput("mid_cur_high", high + high_b, 33);
        checkOutput("mid_cur_period", total + 11, PERIOD);
        measureFrame(high, total);
        checkOutput("mid_next_high", high, 35);

        // Reset mid-pulse, with a simultaneous tick that must lose
        countCycles(10, high);
        rst    = 1'b1;
        tick_i = 1'b1;
        en_i   = 1'b1;
        cmd_i  = 2'b01;
        stepCycle();
        tick_i = 1'b0;
        cmd_i  = 2'b00;
        checkOutput("midrst_pwm", int'(pwm_o), 0);
        checkOutput("midrst_frame", int'(frame_o), 0);
        checkOutput("midrst_pos", int'(pos_o), CENTER);
        repeat (2) stepCycle();
        checkOutput("midrst_pwm_hold", int'(pwm_o), 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("rel_frame_o", int'(frame_o), 1);
        checkOutput("rel_pwm", int'(pwm_o), 1);
        measureFrame(high, total);
        checkOutput("rel_high", high, CENTER);
        checkOutput("rel_period", total, PERIOD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
